// File: rtl/sort_engine.sv
// sort_engine: odd-even transposition sorter, one compare-exchange phase per clock.
// Ports: clock, reset (async active-low), start, descending, data_in -> data_out, busy, done.
module sort_engine #(
  parameter int DIGIT = 4,
  parameter int COUNT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   descending,
  input  logic [COUNT*DIGIT-1:0] data_in,
  output logic [COUNT*DIGIT-1:0] data_out,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic {IDLE, SORT} state_t;

  state_t state;
  state_t state_nx;

  logic [COUNT-1:0][DIGIT-1:0] arr;
  logic [COUNT-1:0][DIGIT-1:0] arr_nx;
  logic [COUNT-2:0]            swap;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               cnt_inc;
  logic                        parity;
  logic                        prev_clean;
  logic                        mode;
  logic                        clean;
  logic                        finish;

  // One phase: disjoint pairs starting at index parity.
  always_comb begin
    arr_nx = arr;
    swap   = '0;
    for (int i = 0; i < COUNT - 1; i++) begin
      if (1'(i % 2) == parity) begin
        if (mode ? (arr[i] < arr[i+1])
                 : (arr[i] > arr[i+1])) begin
          swap[i]     = 1'b1;
          arr_nx[i]   = arr[i+1];
          arr_nx[i+1] = arr[i];
        end
      end
    end
  end

  // Two clean phases in a row cover both parities, so the array is sorted.
  always_comb begin
    cnt_inc = cnt + CW'(1);
    clean   = ~|swap;
    finish  = (clean && prev_clean) ||
              (cnt_inc == CW'(COUNT));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SORT;
      SORT: if (finish) state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SORT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      arr        <= '0;
      cnt        <= '0;
      parity     <= 1'b0;
      prev_clean <= 1'b0;
      mode       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            arr        <= data_in;
            mode       <= descending;
            parity     <= 1'b0;
            cnt        <= '0;
            prev_clean <= 1'b0;
          end
        end
        SORT: begin
          arr        <= arr_nx;
          parity     <= ~parity;
          cnt        <= cnt_inc;
          prev_clean <= clean;
          if (finish) begin
            data_out <= arr_nx;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: scoreboard bench for sort_engine.
// Expected results come from a bubble-sort model queued at start.
module tb_sort_engine;

  localparam int DIGIT = 4;
  localparam int COUNT = 8;
  localparam int W     = DIGIT * COUNT;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         descending = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  always #5 clock = ~clock;

  sort_engine #(.DIGIT(DIGIT), .COUNT(COUNT)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .descending (descending),
    .data_in    (data_in),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] model(
    input logic [W-1:0] d, input logic desc);
    logic [DIGIT-1:0] e[COUNT];
    logic [DIGIT-1:0] t;
    logic [W-1:0]     r;
    for (int i = 0; i < COUNT; i++) e[i] = d[i*DIGIT +: DIGIT];
    for (int p = 0; p < COUNT; p++)
      for (int j = 0; j < COUNT - 1; j++)
        if (desc ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < COUNT; i++) r[i*DIGIT +: DIGIT] = e[i];
    return r;
  endfunction

  // Drive start for one edge (E0); returns at E0+1.
  task automatic start_sort(input logic [W-1:0] d, input logic desc);
    data_in    = d;
    descending = desc;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
    data_in    = W'($urandom);
    descending = 1'($urandom);
    exp_q.push_back(model(d, desc));
  endtask

  task automatic wait_done(input int max, output int n,
                           output bit to, output bit bok);
    n = 0; to = 1'b1; bok = 1'b1;
    for (int k = 0; k < max; k++) begin
      @(posedge clock); #1;
      n++;
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (busy !== 1'b1) bok = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", data_out);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_sorted();
    int n; bit to, bok; logic [W-1:0] e;
    start_sort(32'h76543210, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL sorted_busy_e0: got %b want 1", busy);
    end
    wait_done(20, n, to, bok);
    checks++;
    if (to || n != 2) begin
      errors++; $display("FAIL sorted_latency: got %0d want 2", n);
    end
    checks++;
    if (!bok) begin
      errors++; $display("FAIL sorted_busy_hold: got 0 want 1");
    end
    e = pop_exp();
    checks++;
    if (data_out !== e) begin
      errors++; $display("FAIL sorted_data: got %h want %h", data_out, e);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL sorted_busy_end: got %b want 0", busy);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || data_out !== e) begin
      errors++;
      $display("FAIL sorted_hold: got done=%b data=%h want 0 %h",
               done, data_out, e);
    end
  endtask

  task automatic test_reversed();
    int n; bit to, bok; logic [W-1:0] e;
    start_sort(32'h01234567, 1'b0);
    wait_done(20, n, to, bok);
    checks++;
    if (to || n != COUNT) begin
      errors++; $display("FAIL rev_latency: got %0d want %0d", n, COUNT);
    end
    e = pop_exp();
    checks++;
    if (data_out !== e) begin
      errors++; $display("FAIL rev_data: got %h want %h", data_out, e);
    end
  endtask

  task automatic test_descending();
    int n; bit to, bok; logic [W-1:0] e;
    start_sort(32'h21F09193, 1'b1);
    wait_done(20, n, to, bok);
    checks++;
    if (to || n < 2 || n > COUNT) begin
      errors++; $display("FAIL desc_latency: got %0d want 2..%0d", n, COUNT);
    end
    e = pop_exp();
    checks++;
    if (data_out !== e || data_out !== 32'h0112399F) begin
      errors++;
      $display("FAIL desc_data: got %h want %h", data_out, 32'h0112399F);
    end
  endtask

  task automatic test_dups();
    int n; bit to, bok; logic [W-1:0] e;
    start_sort(32'h55555555, 1'b0);
    wait_done(20, n, to, bok);
    checks++;
    if (to || n != 2) begin
      errors++; $display("FAIL dup_latency: got %0d want 2", n);
    end
    e = pop_exp();
    checks++;
    if (data_out !== e) begin
      errors++; $display("FAIL dup_data: got %h want %h", data_out, e);
    end
    start_sort(32'h0F0F0F0F, 1'b0);
    wait_done(20, n, to, bok);
    e = pop_exp();
    checks++;
    if (to || data_out !== e || data_out !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL ext_data: got %h want %h", data_out, 32'hFFFF0000);
    end
  endtask

  task automatic test_back_to_back();
    int n; int pulses; bit to, bok; logic [W-1:0] e;
    start_sort(32'h01234567, 1'b0);
    @(posedge clock); #1;
    data_in    = 32'h0F0F0F0F;
    descending = 1'b1;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
    wait_done(20, n, to, bok);
    checks++;
    if (to || n + 2 != COUNT) begin
      errors++; $display("FAIL busy_start_latency: got %0d want %0d", n + 2, COUNT);
    end
    e = pop_exp();
    checks++;
    if (data_out !== e) begin
      errors++; $display("FAIL busy_start_data: got %h want %h", data_out, e);
    end
    start_sort(32'h21F09193, 1'b1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
    end
    wait_done(20, n, to, bok);
    e = pop_exp();
    checks++;
    if (to || data_out !== e) begin
      errors++; $display("FAIL b2b_data: got %h want %h", data_out, e);
    end
    pulses = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL no_queued_done: got %0d want 0", pulses);
    end
  endtask

  task automatic test_async_reset();
    int n; int pulses; bit to, bok; logic [W-1:0] e;
    start_sort(32'h01234567, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    e = exp_q.pop_back();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b data=%h want 0 0 0",
               busy, done, data_out);
    end
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL post_reset_idle: got %0d want 0", pulses);
    end
    start_sort(32'h0F0F0F0F, 1'b1);
    wait_done(20, n, to, bok);
    e = pop_exp();
    checks++;
    if (to || data_out !== e) begin
      errors++; $display("FAIL post_reset_data: got %h want %h", data_out, e);
    end
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_reversed();
    test_descending();
    test_dups();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised sorting engine that sorts COUNT unsigned DIGIT-bit values in ascending or descending order. It runs odd-even transposition sort, one compare-exchange phase per clock, and stops early once the array is sorted. A start/busy/done handshake lets it sit behind a register-file or bus front end as a reusable datapath block. This generalises the team's earlier fixed four-element sorter: width, element count and sort direction are configurable, and it adds explicit start, busy and early-termination behaviour.

## Interface
- DIGIT, 4: bit width of each element (≥1).
- COUNT, 8: number of elements (≥2).
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a sort; sampled only in IDLE.
- descending  input  1  0 = ascending, 1 = descending; captured with start.
- data_in  input  COUNT*DIGIT  packed elements; element i = data_in[i*DIGIT +: DIGIT].
- data_out  output  COUNT*DIGIT  sorted result, same packing; element 0 = first in order.
- busy  output  1  high while a sort is in progress.
- done  output  1  one-cycle pulse when data_out is updated.

## Operation
- States: IDLE and SORT.
- Internal: array of COUNT registers; a phase counter of width clog2(COUNT+1); a parity bit; a prev_clean flag; a mode register.
- Reset (reset low, asynchronous):
  - state = IDLE; busy = 0; done = 0; data_out = 0.
  - Array, counter, parity and prev_clean cleared.
  - An in-flight sort is abandoned; no done pulse.
- IDLE: if start = 1 at an edge:
  - Load the array from data_in and the mode from descending.
  - Clear parity to even, the phase counter to 0 and prev_clean to 0.
  - Go to SORT; busy = 1.
- SORT, each edge runs one phase:
  - Even phase compares pairs (0,1), (2,3), …; odd phase compares (1,2), (3,4), ….
  - An element with no partner in the phase is untouched.
  - Pair (i,i+1) swaps when a[i] > a[i+1] in ascending mode, or a[i] < a[i+1] in descending mode. Compares are unsigned.
  - Equal elements never swap, so the sort is stable and equal inputs cause no swap.
  - After each phase: clean = no swap occurred this phase; parity toggles; counter increments; prev_clean <= clean.
- Finish condition, evaluated on the phase just executed: (clean and prev_clean), or counter reaches COUNT.
  - On the finishing edge, data_out <= post-phase array, done <= 1, busy <= 0, state <= IDLE.
- done is cleared on the next edge.
- data_out holds its value until the next completion or reset.
- start while busy = 1 is ignored and not queued.
- start asserted in the same cycle done is high is accepted, since state is already IDLE. data_in is captured on that edge.
- descending and data_in are ignored outside the start-sampling edge.

## Timing
- E0 = edge sampling start in IDLE; busy is high after E0.
- Phases execute on edges E1..EP, with 2 ≤ P ≤ COUNT.
- After EP, done and the new data_out are visible for one cycle, and busy is low.
- Latency from start to done: P+1 edges.
  - Minimum P = 2 (input already sorted).
  - Maximum P = COUNT.
- Back-to-back throughput: one sort per P+1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Already sorted, DIGIT=4, COUNT=8, ascending; data_in elements 0..7 = 0,1,2,3,4,5,6,7 -> done after E2; data_out unchanged; busy high for exactly 2 cycles.
- Reversed input 7,6,5,4,3,2,1,0, ascending -> done after E8 (COUNT cap); data_out = 0,1,…,7.
- Input 3,9,1,9,0,15,1,2 with descending = 1 -> data_out = 15,9,9,3,2,1,1,0.
- Duplicates and extremes: all elements = 5 -> done after E2, output all 5. Input 15,0,15,0,15,0,15,0 ascending -> 0,0,0,0,15,15,15,15.
- Pulse start at E2 of a running sort with different data_in -> ignored; first result correct; no second done. Then start in the done cycle -> a new sort is accepted with the new data.
- Drive reset low mid-sort at E3 -> busy, done and data_out go to 0 immediately, without waiting for a clock edge. After release, no done until a new start; a fresh sort completes correctly.
